// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared types, widths and helpers for the popcount scheduler
package popcount_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;

  // Width of a job total: up to 32 ones per word times MAXW words.
  function automatic int acc_w(input int maxw);
    return $clog2(32 * maxw + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at i_ptr
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  input  logic [NREQ-1:0]         i_req,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_any
);

  localparam int IW = $clog2(NREQ);

  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[w_j]) begin
        o_any       = 1'b1;
        o_gnt[w_j]  = 1'b1;
        o_idx       = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/popcount_scheduler.sv
// rtl/popcount_scheduler.sv - round-robin job scheduler sharing one fixed-latency ones-counter
module popcount_scheduler
  import popcount_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MAXW = 4,
  parameter int LAT  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*WORD_W-1:0]     req_data,
  input  logic [NREQ-1:0]            req_last,
  output logic [WORD_W-1:0]          cnt_data,
  output logic                       cnt_valid,
  input  logic [CNT_W-1:0]           cnt_count,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [acc_w(MAXW)-1:0]     rsp_count,
  output logic                       rsp_trunc
);

  localparam int IW    = $clog2(NREQ);
  localparam int ACC_W = acc_w(MAXW);
  localparam int WC_W  = $clog2(MAXW + 1);

  state_e            r_state;
  logic [NREQ-1:0]   r_gnt_oh;
  logic [IW-1:0]     r_gnt_idx;
  logic [IW-1:0]     r_ptr;
  logic [WC_W-1:0]   r_wcnt;
  logic              r_trunc;
  logic [ACC_W-1:0]  r_acc;
  logic              r_cnt_last;
  logic [LAT-1:0]    r_pv;
  logic [LAT-1:0]    r_pl;

  logic [NREQ-1:0]   w_gnt;
  logic [IW-1:0]     w_idx;
  logic              w_any;
  logic              w_accept;
  logic              w_at_max;
  logic              w_word_last;
  logic              w_head_v;
  logic              w_head_l;
  logic [ACC_W-1:0]  w_sum;
  logic [WORD_W-1:0] w_data;
  logic [IW-1:0]     w_next_ptr;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_ptr (r_ptr),
    .i_req (req_valid),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign req_ready   = (r_state == ISSUE) ? r_gnt_oh : '0;
  assign w_data      = req_data[WORD_W*r_gnt_idx +: WORD_W];
  assign w_accept    = (r_state == ISSUE) && req_valid[r_gnt_idx];
  assign w_at_max    = (r_wcnt == WC_W'(MAXW - 1));
  assign w_word_last = req_last[r_gnt_idx] || w_at_max;
  // The pipe is fed from the registered cnt_valid, so its head lines up with cnt_count.
  assign w_head_v    = r_pv[LAT-1];
  assign w_head_l    = r_pl[LAT-1];
  assign w_sum       = r_acc + ACC_W'(cnt_count);
  assign w_next_ptr  = (r_gnt_idx == IW'(NREQ - 1)) ? '0 : r_gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt_oh   <= '0;
      r_gnt_idx  <= '0;
      r_ptr      <= '0;
      r_wcnt     <= '0;
      r_trunc    <= 1'b0;
      r_acc      <= '0;
      r_cnt_last <= 1'b0;
      r_pv       <= '0;
      r_pl       <= '0;
      cnt_data   <= '0;
      cnt_valid  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_count  <= '0;
      rsp_trunc  <= 1'b0;
    end else begin
      r_pv       <= LAT'({r_pv, cnt_valid});
      r_pl       <= LAT'({r_pl, r_cnt_last});
      cnt_valid  <= w_accept;
      r_cnt_last <= w_accept && w_word_last;
      if (w_accept) cnt_data <= w_data;
      if (w_head_v) r_acc <= w_sum;

      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt_oh  <= w_gnt;
            r_gnt_idx <= w_idx;
            r_wcnt    <= '0;
            r_trunc   <= 1'b0;
            r_acc     <= '0;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_accept) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (w_word_last) begin
              r_trunc <= !req_last[r_gnt_idx];
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_head_v && w_head_l) begin
            rsp_valid <= 1'b1;
            rsp_count <= w_sum;
            rsp_id    <= r_gnt_idx;
            rsp_trunc <= r_trunc;
            r_state   <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_ptr     <= w_next_ptr;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_scheduler.sv
// tb/tb_popcount_scheduler.sv - scoreboard bench for popcount_scheduler with a behavioural counter
module tb_popcount_scheduler;

  localparam int NREQ = 4;
  localparam int MAXW = 4;
  localparam int LAT  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_data;
  logic [NREQ-1:0]      req_last;
  logic [31:0]          cnt_data;
  logic                 cnt_valid;
  logic [5:0]           cnt_count;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [7:0]           rsp_count;
  logic                 rsp_trunc;

  popcount_scheduler #(.NREQ(NREQ), .MAXW(MAXW), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_last  (req_last),
    .cnt_data  (cnt_data),
    .cnt_valid (cnt_valid),
    .cnt_count (cnt_count),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .rsp_trunc (rsp_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int cnt;
    int trunc;
  } exp_t;

  exp_t        exp_q[$];
  logic [33:0] rq[NREQ][$];
  logic [5:0]  cpipe[LAT];
  int          n_vec = 0;
  int          n_err = 0;

  // External counter: fixed LAT-cycle latency, no handshake.
  always @(posedge clk) begin
    cpipe[0] <= cnt_valid ? 6'($countones(cnt_data)) : 6'd0;
    for (int k = 1; k < LAT; k++) cpipe[k] <= cpipe[k-1];
  end
  assign cnt_count = cpipe[LAT-1];

  // Requester models: each queue entry is {bubble, last, data}.
  always @(posedge clk) begin
    logic [33:0] f;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        f = rq[i][0];
        if (f[33] || (req_valid[i] && req_ready[i])) void'(rq[i].pop_front());
      end
    end
    #1;
    for (int i = 0; i < NREQ; i++) begin
      f = '0;
      if (rq[i].size() > 0) f = rq[i][0];
      req_valid[i]          = (rq[i].size() > 0) && !f[33];
      req_last[i]           = f[32];
      req_data[32*i +: 32]  = f[31:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id",    32'(rsp_id),    32'(e.id));
        chk("rsp_count", 32'(rsp_count), 32'(e.cnt));
        chk("rsp_trunc", 32'(rsp_trunc), 32'(e.trunc));
      end
    end
  end

  task automatic push_word(input int r, input logic [31:0] d, input logic last, input logic bub);
    rq[r].push_back({bub, last, d});
  endtask

  task automatic expect_rsp(input int id, input int cnt, input int trunc);
    exp_t e;
    e.id = id; e.cnt = cnt; e.trunc = trunc;
    exp_q.push_back(e);
  endtask

  // Edge 0 is the first edge that sees req_valid[r]; returns the edge that first samples rsp_valid.
  task automatic measure(input int r, output int e);
    int g, c;
    e = -1;
    g = 0;
    while (!req_valid[r] && g < 100) begin @(negedge clk); g++; end
    @(posedge clk);
    c = 0;
    while (c < 100) begin
      @(negedge clk);
      if (rsp_valid) begin e = c + 1; break; end
      @(posedge clk);
      c++;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || rsp_valid) && g < 300) begin @(negedge clk); g++; end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, g;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_cnt_valid", 32'(cnt_valid), 32'd0);
    chk("rst_cnt_data",  cnt_data,       32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_count", 32'(rsp_count), 32'd0);
    chk("rst_rsp_trunc", 32'(rsp_trunc), 32'd0);
    rst_n = 1'b1;

    // Single all-ones word from requester 1.
    @(negedge clk);
    expect_rsp(1, 32, 0);
    push_word(1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    measure(1, e);
    chk("lat_single", 32'(e), 32'd7);
    wait_idle();

    // Three words from requester 0, back to back.
    @(negedge clk);
    expect_rsp(0, 6, 0);
    push_word(0, 32'h0000_000F, 1'b0, 1'b0);
    push_word(0, 32'h8000_0001, 1'b0, 1'b0);
    push_word(0, 32'h0000_0000, 1'b1, 1'b0);
    measure(0, e);
    chk("lat_3word", 32'(e), 32'd9);
    wait_idle();

    // Same job with a one-cycle bubble after the first word.
    @(negedge clk);
    expect_rsp(0, 6, 0);
    push_word(0, 32'h0000_000F, 1'b0, 1'b0);
    push_word(0, 32'h0000_0000, 1'b0, 1'b1);
    push_word(0, 32'h8000_0001, 1'b0, 1'b0);
    push_word(0, 32'h0000_0000, 1'b1, 1'b0);
    measure(0, e);
    chk("lat_bubble", 32'(e), 32'd10);
    wait_idle();

    // Six words cut at MAXW=4: remainder forms a second job.
    @(negedge clk);
    expect_rsp(2, 4, 1);
    expect_rsp(2, 2, 0);
    for (int i = 0; i < 6; i++) push_word(2, 32'h1, (i == 5), 1'b0);
    wait_idle();

    // Back-pressure on the response while another requester waits.
    @(negedge clk);
    rsp_ready = 1'b0;
    expect_rsp(3, 8, 0);
    expect_rsp(1, 3, 0);
    push_word(3, 32'h0000_00FF, 1'b1, 1'b0);
    push_word(1, 32'h0000_0007, 1'b1, 1'b0);
    g = 0;
    while (!rsp_valid && g < 100) begin @(negedge clk); g++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid",     32'(rsp_valid), 32'd1);
      chk("hold_id",        32'(rsp_id),    32'd3);
      chk("hold_count",     32'(rsp_count), 32'd8);
      chk("hold_trunc",     32'(rsp_trunc), 32'd0);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_cnt_valid", 32'(cnt_valid), 32'd0);
    end
    rsp_ready = 1'b1;
    wait_idle();

    // All four requesters valid out of reset, then requester 0 comes back.
    enter_reset();
    expect_rsp(0, 1, 0);
    expect_rsp(1, 2, 0);
    expect_rsp(2, 3, 0);
    expect_rsp(3, 4, 0);
    push_word(0, 32'h0000_0001, 1'b1, 1'b0);
    push_word(1, 32'h0000_0003, 1'b1, 1'b0);
    push_word(2, 32'h0000_0007, 1'b1, 1'b0);
    push_word(3, 32'h0000_000F, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    g = 0;
    while (exp_q.size() > 3 && g < 100) begin @(negedge clk); g++; end
    expect_rsp(0, 8, 0);
    push_word(0, 32'h0000_00FF, 1'b1, 1'b0);
    wait_idle();

    // Reset while a job drains; its in-flight result must be dropped.
    @(negedge clk);
    push_word(1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    g = 0;
    while (!cnt_valid && g < 100) begin @(negedge clk); g++; end
    enter_reset();
    @(negedge clk);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    expect_rsp(0, 2, 0);
    push_word(0, 32'h0000_0003, 1'b1, 1'b0);
    measure(0, e);
    chk("lat_after_rst", 32'(e), 32'd7);
    wait_idle();
    repeat (10) @(negedge clk);
    chk("no_stale_rsp", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/popcount_scheduler.md
# popcount_scheduler

Sequencing and arbitration controller that shares one fixed-latency 32-input ones-counter among NREQ requesters. Each requester submits a job of one or more 32-bit words. The scheduler grants jobs round-robin, streams the granted job's words into the counter, and tracks in-flight words with a valid/last shift register, because the counter has no handshake. It accumulates the returned 6-bit counts and hands back one total per job. It sits between the requester ports and the pipelined, path-balanced counter datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- MAXW, 4, maximum words per job (1..16)
- LAT, 4, counter latency in cycles, from cnt_valid to the matching cnt_count (1..16)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  word valid, one bit per requester
- req_ready  out  NREQ  word accepted; at most one bit set
- req_data  in  NREQ*32  word for requester i in bits [32i+31:32i]
- req_last  in  NREQ  marks the final word of the job
- cnt_data  out  32  word to the counter
- cnt_valid  out  1  cnt_data valid this cycle (internal tracking only; the counter ignores it)
- cnt_count  in  6  counter result (0..32), valid exactly LAT cycles after its cnt_valid
- rsp_valid  out  1  job result valid
- rsp_ready  in  1  result consumed
- rsp_id  out  clog2(NREQ)  requester index of the job
- rsp_count  out  clog2(32*MAXW+1)  total ones in the job
- rsp_trunc  out  1  job was cut at MAXW words

## Operation
- FSM states and transitions:
  - IDLE: if any req_valid is set, register the grant from rr_arbiter, go to ISSUE.
  - ISSUE: req_ready[g]=1. Each accepted word is registered onto cnt_data/cnt_valid the next cycle, and wcnt increments.
    - Accepting a word with req_last=1 ends ISSUE and goes to DRAIN.
    - Accepting word number MAXW with req_last=0 also ends ISSUE, goes to DRAIN, and sets trunc.
    - Cycles with req_valid[g]=0 are bubbles: nothing is issued and the FSM stays in ISSUE.
  - DRAIN: req_ready=0. When the tracked last result returns, add it and go to RESP.
  - RESP: rsp_valid=1. When rsp_ready=1, go to IDLE and set the round-robin pointer to g+1 (mod NREQ).
- Tracking pipe: an LAT-deep shift register of {valid,last}. Each cycle its head's valid bit qualifies cnt_count, and the sum updates as acc <= acc + cnt_count.
- acc clears on entry to ISSUE. Width clog2(32*MAXW+1) never overflows.
- Arbitration: round-robin starting at the pointer. The pointer resets to 0, so requester 0 wins the first simultaneous contention.
- Truncation: words left over after a MAXW cut stay pending on that requester and form a new job on a later grant.
- Reset mid-operation clears the FSM, the tracking pipe, acc and the pointer. Counter results still in flight are discarded, since nothing tracks them.

## Timing
- Reset values:
  - req_ready=0, cnt_valid=0, cnt_data=0
  - rsp_valid=0, rsp_id=0, rsp_count=0, rsp_trunc=0
  - FSM=IDLE
- Grant: one cycle in IDLE. The first req_ready is high the cycle after req_valid is first seen in IDLE.
- Word accepted at edge E drives cnt_valid during cycle E+1. Its cnt_count is sampled at edge E+1+LAT.
- Single-word job: req_valid seen at edge 0, accepted at edge 1, rsp_valid at edge LAT+3.
- Job of N words with no bubbles: rsp_valid at edge N+LAT+2.
- rsp_id, rsp_count and rsp_trunc hold stable while rsp_valid=1 and rsp_ready=0.
- Throughput: one word per cycle in ISSUE. Per job, LAT+3 cycles of overhead (grant, drain, response) are not overlapped.
- req_valid dropping or changing on non-granted requesters has no effect. Per-requester valid/data stability is the requester's obligation.

## Structure
- popcount_pkg:
  - WORD_W=32, CNT_W=6
  - state enum {IDLE, ISSUE, DRAIN, RESP}
  - function acc_w(MAXW) = clog2(32*MAXW+1)
- Sub-module rr_arbiter (NREQ, pointer in, request vector in, one-hot and index grant out). Purely combinational; the scheduler registers its output.
- The counter itself is external; the scheduler contains no popcount logic.

## Test plan
- LAT=4. Requester 1 sends one word 0xFFFF_FFFF with last -> rsp_id=1, rsp_count=32, rsp_trunc=0, rsp_valid at edge 7.
- Requester 0 sends 3 words 0x0000_000F, 0x8000_0001, 0 -> rsp_count=6, rsp_valid at edge 9. Repeat with one bubble between words: rsp_count=6, rsp_valid at edge 10.
- All 4 requesters valid from reset with single-word jobs -> responses in order 0,1,2,3. Requester 0 re-requests after its response and is served after 3.
- MAXW=4, requester 2 sends 6 words of 0x1 with last on word 6 -> first rsp_count=4 with rsp_trunc=1, then a second job rsp_count=2 with rsp_trunc=0.
- Hold rsp_ready=0 for 10 cycles -> rsp_* stable, req_ready=0 throughout, nothing issued.
- Assert rst_n=0 while in DRAIN, release, then run a single-word job 0x3 -> no stale response, rsp_count=2.
